// File: rtl/vote_tally.sv
// Multi-cycle weighted ballot tally: one vote per voter per session, weighted
// saturating total, threshold decision pulsed out one cycle after close.
module vote_tally #(
  parameter int NP_N    = 32,
  parameter int VIP_N   = 8,
  parameter int VVIP_N  = 1,
  parameter int NP_WT   = 1,
  parameter int VIP_WT  = 4,
  parameter int VVIP_WT = 16,
  parameter int THRESH  = 32,
  parameter int SUM_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ballot_valid,
  input  logic [NP_N-1:0]   np,
  input  logic [VIP_N-1:0]  vip,
  input  logic [VVIP_N-1:0] vvip,
  input  logic              close,
  output logic              busy,
  output logic [SUM_W-1:0]  total,
  output logic              early_pass,
  output logic              res_valid,
  output logic              res
);

  localparam int EXT_W = SUM_W + 2;
  localparam logic [EXT_W-1:0] SAT_MAX  = EXT_W'((1 << SUM_W) - 1);
  localparam logic [EXT_W-1:0] THRESH_X = EXT_W'(THRESH);
  localparam logic [EXT_W-1:0] NP_W_X   = EXT_W'(NP_WT);
  localparam logic [EXT_W-1:0] VIP_W_X  = EXT_W'(VIP_WT);
  localparam logic [EXT_W-1:0] VVIP_W_X = EXT_W'(VVIP_WT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic clear;
  logic accept;
  logic load_res;

  logic [NP_N-1:0]   np_mask;
  logic [VIP_N-1:0]  vip_mask;
  logic [VVIP_N-1:0] vvip_mask;
  logic              res_q;

  logic [NP_N-1:0]   new_np;
  logic [VIP_N-1:0]  new_vip;
  logic [VVIP_N-1:0] new_vvip;
  logic [EXT_W-1:0]  cnt_np;
  logic [EXT_W-1:0]  cnt_vip;
  logic [EXT_W-1:0]  cnt_vvip;
  logic [EXT_W-1:0]  sum;
  logic [SUM_W-1:0]  total_upd;
  logic [SUM_W-1:0]  total_next;
  logic              pass_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block is given a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    accept     = 1'b0;
    load_res   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = OPEN;
          clear      = 1'b1;
        end
      end
      OPEN: begin
        // close outranks start; a ballot on close is still counted.
        if (close) begin
          accept     = ballot_valid;
          load_res   = 1'b1;
          state_next = DONE;
        end else if (start) begin
          clear      = 1'b1;
        end else begin
          accept     = ballot_valid;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    new_np   = np   & ~np_mask;
    new_vip  = vip  & ~vip_mask;
    new_vvip = vvip & ~vvip_mask;

    cnt_np = '0;
    for (int i = 0; i < NP_N; i++) cnt_np = cnt_np + EXT_W'(new_np[i]);
    cnt_vip = '0;
    for (int i = 0; i < VIP_N; i++) cnt_vip = cnt_vip + EXT_W'(new_vip[i]);
    cnt_vvip = '0;
    for (int i = 0; i < VVIP_N; i++) cnt_vvip = cnt_vvip + EXT_W'(new_vvip[i]);

    sum = {2'b00, total} + cnt_np * NP_W_X + cnt_vip * VIP_W_X
        + cnt_vvip * VVIP_W_X;
    total_upd  = (sum > SAT_MAX) ? SAT_MAX[SUM_W-1:0] : sum[SUM_W-1:0];
    total_next = accept ? total_upd : total;
    pass_next  = ({2'b00, total_next} >= THRESH_X);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      np_mask   <= '0;
      vip_mask  <= '0;
      vvip_mask <= '0;
      total     <= '0;
      res_q     <= 1'b0;
    end else if (clear) begin
      np_mask   <= '0;
      vip_mask  <= '0;
      vvip_mask <= '0;
      total     <= '0;
      res_q     <= 1'b0;
    end else begin
      if (accept) begin
        np_mask   <= np_mask   | np;
        vip_mask  <= vip_mask  | vip;
        vvip_mask <= vvip_mask | vvip;
        total     <= total_upd;
      end
      if (load_res) res_q <= pass_next;
    end
  end

  assign busy       = (state == OPEN);
  assign res_valid  = (state == DONE);
  assign res        = res_q;
  assign early_pass = ({2'b00, total} >= THRESH_X) && (state != IDLE);

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: two instances (default width and a 6-bit saturating
// accumulator) driven in lockstep, checked each cycle against a set-based model.
module tb_vote_tally;

  localparam int THR   = 32;
  localparam int MAX_A = 255;
  localparam int MAX_B = 63;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ballot_valid = 1'b0;
  logic        close = 1'b0;
  logic [31:0] np = '0;
  logic [7:0]  vip = '0;
  logic [0:0]  vvip = '0;

  logic       busy_a, early_a, rv_a, res_a;
  logic [7:0] total_a;
  logic       busy_b, early_b, rv_b, res_b;
  logic [5:0] total_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vote_tally dut_a (
    .clk(clk), .reset(reset), .start(start), .ballot_valid(ballot_valid),
    .np(np), .vip(vip), .vvip(vvip), .close(close),
    .busy(busy_a), .total(total_a), .early_pass(early_a),
    .res_valid(rv_a), .res(res_a)
  );

  vote_tally #(.SUM_W(6)) dut_b (
    .clk(clk), .reset(reset), .start(start), .ballot_valid(ballot_valid),
    .np(np), .vip(vip), .vvip(vvip), .close(close),
    .busy(busy_b), .total(total_b), .early_pass(early_b),
    .res_valid(rv_b), .res(res_b)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the set of voters who have voted this session; the total is the
  // weighted size of that set clipped to the accumulator ceiling.
  bit [31:0] m_np;
  bit [7:0]  m_vip;
  bit        m_vvip;
  bit        m_open, m_done, m_res_a, m_res_b;

  function automatic int m_raw();
    return $countones(m_np) + 4 * $countones(m_vip) + 16 * int'(m_vvip);
  endfunction

  function automatic int m_sat(input int mx);
    int r;
    r = m_raw();
    return (r > mx) ? mx : r;
  endfunction

  task automatic m_clear();
    m_np = '0; m_vip = '0; m_vvip = 1'b0;
    m_res_a = 1'b0; m_res_b = 1'b0;
  endtask

  task automatic m_ballot();
    if (ballot_valid) begin
      m_np = m_np | np; m_vip = m_vip | vip; m_vvip = m_vvip | vvip[0];
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clear();
      m_open = 1'b0;
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_open) begin
      if (start) begin
        m_clear();
        m_open = 1'b1;
      end
    end else if (close) begin
      m_ballot();
      m_res_a = (m_sat(MAX_A) >= THR);
      m_res_b = (m_sat(MAX_B) >= THR);
      m_open  = 1'b0;
      m_done  = 1'b1;
    end else if (start) begin
      m_clear();
    end else begin
      m_ballot();
    end
  end

  always @(negedge clk) begin
    check("busy_a",  busy_a,  m_open);
    check("total_a", total_a, m_sat(MAX_A));
    check("early_a", early_a, (m_sat(MAX_A) >= THR) && (m_open || m_done));
    check("rvalid_a", rv_a,   m_done);
    check("res_a",   res_a,   m_res_a);
    check("busy_b",  busy_b,  m_open);
    check("total_b", total_b, m_sat(MAX_B));
    check("early_b", early_b, (m_sat(MAX_B) >= THR) && (m_open || m_done));
    check("rvalid_b", rv_b,   m_done);
    check("res_b",   res_b,   m_res_b);
  end

  task automatic cyc(input logic s, input logic bv, input logic [31:0] n,
                     input logic [7:0] v, input logic vv, input logic c);
    start = s; ballot_valid = bv; np = n; vip = v; vvip = vv; close = c;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_total", total_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_res", res_a, 0);

    // Full NP turnout reaches the threshold exactly.
    cyc(1, 0, 32'h0, 8'h0, 0, 0);
    cyc(0, 1, 32'hFFFF_FFFF, 8'h0, 0, 0);
    check("t1_total", total_a, 32);
    check("t1_early", early_a, 1);
    cyc(0, 0, 32'h0, 8'h0, 0, 1);
    check("t1_rvalid", rv_a, 1);
    check("t1_res", res_a, 1);
    idle();
    check("t1_rvalid_off", rv_a, 0);
    check("t1_res_held", res_a, 1);
    // Ballot and close in IDLE are ignored.
    cyc(0, 1, 32'hFFFF_FFFF, 8'hFF, 1, 1);
    check("idle_total", total_a, 32);
    check("idle_early", early_a, 0);
    check("idle_rvalid", rv_a, 0);

    // Repeat votes count once; start during DONE is ignored.
    cyc(1, 0, 32'h0, 8'h0, 0, 0);
    check("t2_res_clr", res_a, 0);
    repeat (4) cyc(0, 1, 32'h0000_000F, 8'h0, 0, 0);
    check("t2_total", total_a, 4);
    cyc(0, 0, 32'h0, 8'h0, 0, 1);
    check("t2_res", res_a, 0);
    cyc(1, 0, 32'h0, 8'h0, 0, 0);
    check("t2_done_start", busy_a, 0);

    // Ballot in the close cycle is counted: 16 + 4*4 = 32.
    cyc(1, 0, 32'h0, 8'h0, 0, 0);
    cyc(0, 1, 32'h0, 8'h0F, 1, 1);
    check("t3_rvalid", rv_a, 1);
    check("t3_total", total_a, 32);
    check("t3_res", res_a, 1);
    idle();

    // 32 + 32 + 16 = 80; 6-bit instance saturates at 63; close beats start.
    cyc(1, 0, 32'h0, 8'h0, 0, 0);
    cyc(0, 1, 32'h0, 8'hFF, 0, 0);
    cyc(0, 1, 32'hFFFF_FFFF, 8'h0, 0, 0);
    cyc(0, 1, 32'h0, 8'h0, 1, 0);
    check("t4_total_a", total_a, 80);
    check("t4_total_b", total_b, 63);
    cyc(1, 0, 32'h0, 8'h0, 0, 1);
    check("t4_close_wins", rv_a, 1);
    check("t4_total_kept", total_a, 80);
    idle();

    // Restart clears state and discards its own ballot.
    cyc(1, 0, 32'h0, 8'h0, 0, 0);
    cyc(0, 1, 32'h7FFF_FFFF, 8'h0, 0, 0);
    check("t5_total31", total_a, 31);
    check("t5_early31", early_a, 0);
    cyc(1, 1, 32'hFFFF_FFFF, 8'h0, 0, 0);
    check("t5_restart", total_a, 0);
    check("t5_busy", busy_a, 1);
    cyc(0, 1, 32'h0000_0001, 8'h0, 0, 0);
    cyc(0, 0, 32'h0, 8'h0, 0, 1);
    check("t5_total", total_a, 1);
    check("t5_res", res_a, 0);
    idle();

    // Asynchronous reset mid-session.
    cyc(1, 0, 32'h0, 8'h0, 0, 0);
    cyc(0, 1, 32'h0, 8'hFF, 0, 0);
    check("t6_total", total_a, 32);
    #2 reset = 1'b1;
    #1;
    check("t6_async_total", total_a, 0);
    check("t6_async_busy", busy_a, 0);
    check("t6_async_early", early_a, 0);
    check("t6_async_rvalid", rv_a, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 0, 32'h0, 8'h0, 0, 0);
    cyc(0, 0, 32'h0, 8'h0, 0, 1);
    check("t6_rvalid", rv_a, 1);
    check("t6_res", res_a, 0);
    check("t6_total_end", total_a, 0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vote_tally.md
Name: vote_tally

Overview:
- Sequential, parametrised successor to the combinational weighted voter.
- Collects ballots over multiple cycles within a session and counts each voter at most once.
- Accumulates a weighted total with three voter classes (NP, VIP, VVIP); the result is a threshold decision issued on session close, plus an early-pass flag.
- Sits between a ballot source (testbench or CPU-side peripheral) and the consumer of the pass/fail result.

Parameters:
- NP_N, 32, number of normal voters (np bit width)
- VIP_N, 8, number of VIP voters (vip bit width)
- VVIP_N, 1, number of VVIP voters (vvip bit width)
- NP_WT, 1, weight per NP vote
- VIP_WT, 4, weight per VIP vote
- VVIP_WT, 16, weight per VVIP vote
- THRESH, 32, pass threshold; pass when total >= THRESH
- SUM_W, 8, width of the total accumulator; saturates at 2^SUM_W-1

Ports:
- clk, input, 1, system clock, rising edge
- reset, input, 1, asynchronous active-high reset
- start, input, 1, open a new session (clears masks and total)
- ballot_valid, input, 1, qualifies np/vip/vvip this cycle
- np, input, NP_N, NP ballot bits (1 = vote yes)
- vip, input, VIP_N, VIP ballot bits
- vvip, input, VVIP_N, VVIP ballot bits
- close, input, 1, end the session and request a result
- busy, output, 1, session open (state OPEN)
- total, output, SUM_W, current weighted total (registered)
- early_pass, output, 1, total >= THRESH during OPEN/DONE
- res_valid, output, 1, one-cycle pulse carrying the final result
- res, output, 1, final decision, held until next start or reset

Behaviour:
- Reset is asynchronous and active-high; clock and reset ports are named clk and reset.
- Reset values: state=IDLE, all voted masks=0, total=0, busy=0, early_pass=0, res_valid=0, res=0.

States (encoding free):
- IDLE: start -> OPEN (clears masks and total). close and ballot_valid are ignored.
- OPEN: busy=1.
  - If ballot_valid, new votes = ballot & ~mask per class. Masks |= ballot. total += popcount(new_np)*NP_WT + popcount(new_vip)*VIP_WT + popcount(new_vvip)*VVIP_WT.
  - close -> DONE.
  - start (without close) -> remain OPEN with masks and total cleared; any ballot in that cycle is discarded.
- DONE: lasts exactly one cycle.
  - res_valid=1 and res=(total>=THRESH), where total includes any ballot accepted in the close cycle.
  - Next state is IDLE. start in DONE is ignored.

Timing:
- A ballot accepted at edge t is visible on total after edge t.
- close sampled at edge t gives res_valid high for the cycle following t.
- ballot_valid and close in the same cycle: the ballot is counted, then the session closes.
- start and close in the same OPEN cycle: close wins, and start is ignored.

Arithmetic:
- Per-class popcount is computed at full width.
- The sum is formed in SUM_W+2 bits, then saturated to 2^SUM_W-1.
- Repeat votes from an already-masked voter add 0.
- A ballot bit of 0 never clears a mask bit.

Outputs:
- early_pass = (total >= THRESH) && state != IDLE.
- res holds its value through IDLE. It clears on start and on reset.
- Reset during OPEN aborts the session; no res_valid is produced.

Test Plan:
- Reset, start, 1 ballot with np=32'hFFFFFFFF, close -> total=32, early_pass=1 after ballot, res_valid pulse with res=1.
- start; ballot np=32'h0000000F, then the same ballot 3 more times; close -> total=4 (duplicates ignored), res=0.
- start; ballot vvip=1, vip=8'h0F in one cycle; close asserted in that same cycle -> total=32, res_valid next cycle, res=1.
- start; ballots vip=8'hFF, np=32'hFFFFFFFF, vvip=1 -> total=80, no wrap. With SUM_W=6 override -> total=63 (saturated).
- start; ballot np=32'h7FFFFFFF (31); start again; ballot np=1; close -> total=1, res=0 (restart cleared state).
- start; ballot vip=8'hFF (32); assert reset mid-session -> all outputs 0 immediately and asynchronously, no res_valid. Then start, close -> res=0, total=0.
